// File: rtl/prt_scaler_pkg.sv
// Shared types and helpers for the scaler sliding-window pipeline stages.
package prt_scaler_pkg;

  // Widest window the tap selector supports (16 taps -> 4 select bits).
  localparam int SEL_W_MAX = 4;

  // Tap index type, wide enough for any supported window size.
  typedef logic [SEL_W_MAX-1:0] tap_sel_t;

  // Select width for a given tap count; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

  // Clamp an index into the window; anything past the end maps to the last tap.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned taps);
    return (sel >= taps) ? (taps - 1) : sel;
  endfunction

endpackage

// File: rtl/prt_scaler_skid.sv
// One-entry skid buffer with registered ready, generic payload width.
// The output register always drains the skid entry first so beat order is kept.
module prt_scaler_skid #(
  parameter int P_W = 8
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  logic           in_vld_i,
  output logic           in_rdy_o,
  input  logic [P_W-1:0] in_dat_i,
  output logic           out_vld_o,
  input  logic           out_rdy_i,
  output logic [P_W-1:0] out_dat_o
);

  logic           out_vld_q, out_vld_d;
  logic [P_W-1:0] out_dat_q, out_dat_d;
  logic           skid_vld_q, skid_vld_d;
  logic [P_W-1:0] skid_dat_q, skid_dat_d;
  logic           rdy_q, rdy_d;
  logic           accept;
  logic           out_load;

  // Next-state: route accepted beats to the output register or the skid entry.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    accept     = in_vld_i & rdy_q;
    out_load   = ~out_vld_q | out_rdy_i;

    if (out_load) begin
      if (skid_vld_q) begin
        // Skid has priority; a concurrent accept refills the skid.
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = accept;
        if (accept) begin
          skid_dat_d = in_dat_i;
        end
      end else if (accept) begin
        out_vld_d = 1'b1;
        out_dat_d = in_dat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the beat in the skid entry.
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat_i;
    end

    rdy_d = ~skid_vld_d;
  end

  // State registers; reset drops any beat in flight.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      rdy_q      <= 1'b1;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_rdy_o  = rdy_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

endmodule

// File: rtl/prt_scaler_slw_mux_pipe.sv
// Sliding-window tap selector: picks one tap (clamped to the window) and,
// when PRT_SCALER_SLW_MUX_PAIR_EN is defined, also its right neighbour,
// then registers them with the side-band bits through a skid stage.
// Without the macro DAT1_OUT is tied low and no neighbour logic exists.
module prt_scaler_slw_mux_pipe
  import prt_scaler_pkg::*;
#(
  parameter int P_BPC   = 8,
  parameter int P_CMP   = 3,
  parameter int P_TAPS  = 7,
  // Derived from P_TAPS; not meant to be overridden.
  parameter int P_SEL_W = sel_w(P_TAPS),
  parameter int P_USR   = 4
) (
  input  logic                          CLK_IN,
  input  logic                          RST_IN,
  input  logic [P_TAPS*P_CMP*P_BPC-1:0] DAT_IN,
  input  logic [P_SEL_W-1:0]            SEL_IN,
  input  logic [P_USR-1:0]              USR_IN,
  input  logic                          VLD_IN,
  output logic                          RDY_OUT,
  output logic [P_CMP*P_BPC-1:0]        DAT0_OUT,
  output logic [P_CMP*P_BPC-1:0]        DAT1_OUT,
  output logic [P_USR-1:0]              USR_OUT,
  output logic                          VLD_OUT,
  input  logic                          RDY_IN
);

  localparam int L_PIX_W = P_CMP * P_BPC;
`ifdef PRT_SCALER_SLW_MUX_PAIR_EN
  localparam int L_PAY_W = P_USR + 2 * L_PIX_W;
`else
  localparam int L_PAY_W = P_USR + L_PIX_W;
`endif

  logic [L_PIX_W-1:0] tap_w [P_TAPS];
  tap_sel_t           sel_c;
  logic [L_PIX_W-1:0] dat0_w;
  logic [L_PAY_W-1:0] pay_in_w;
  logic [L_PAY_W-1:0] pay_out_w;

  // Unpack the flat window into per-tap pixels.
  generate
    for (genvar gi = 0; gi < P_TAPS; gi++) begin : g_tap
      assign tap_w[gi] = DAT_IN[gi*L_PIX_W +: L_PIX_W];
    end
  endgenerate

  // Clamp the select and pick the selected tap.
  always_comb begin
    sel_c  = tap_sel_t'(clamp_sel(32'(SEL_IN), 32'(P_TAPS)));
    dat0_w = '0;
    for (int i = 0; i < P_TAPS; i++) begin
      if (sel_c == tap_sel_t'(i)) begin
        dat0_w = tap_w[i];
      end
    end
  end

`ifdef PRT_SCALER_SLW_MUX_PAIR_EN
  tap_sel_t           nbr_c;
  logic [L_PIX_W-1:0] dat1_w;

  // Neighbour tap, replicating the last tap at the right edge.
  always_comb begin
    nbr_c  = tap_sel_t'(clamp_sel(32'(sel_c) + 32'd1, 32'(P_TAPS)));
    dat1_w = '0;
    for (int i = 0; i < P_TAPS; i++) begin
      if (nbr_c == tap_sel_t'(i)) begin
        dat1_w = tap_w[i];
      end
    end
  end

  assign pay_in_w = {USR_IN, dat1_w, dat0_w};
  assign DAT1_OUT = pay_out_w[L_PIX_W +: L_PIX_W];
  assign USR_OUT  = pay_out_w[2*L_PIX_W +: P_USR];
`else
  assign pay_in_w = {USR_IN, dat0_w};
  assign DAT1_OUT = '0;
  assign USR_OUT  = pay_out_w[L_PIX_W +: P_USR];
`endif

  assign DAT0_OUT = pay_out_w[0 +: L_PIX_W];

  prt_scaler_skid #(
    .P_W (L_PAY_W)
  ) u_skid (
    .clk_i     (CLK_IN),
    .srst_i    (RST_IN),
    .in_vld_i  (VLD_IN),
    .in_rdy_o  (RDY_OUT),
    .in_dat_i  (pay_in_w),
    .out_vld_o (VLD_OUT),
    .out_rdy_i (RDY_IN),
    .out_dat_o (pay_out_w)
  );

endmodule

// File: tb/tb_prt_scaler_slw_mux_pipe.sv
// Scoreboard bench for prt_scaler_slw_mux_pipe (7 taps x 3 x 8 bits).
// Builds with or without PRT_SCALER_SLW_MUX_PAIR_EN.
module tb_prt_scaler_slw_mux_pipe;

  logic         CLK_IN = 1'b0;
  logic         RST_IN;
  logic [167:0] DAT_IN;
  logic [2:0]   SEL_IN;
  logic [3:0]   USR_IN;
  logic         VLD_IN;
  logic         RDY_OUT;
  logic [23:0]  DAT0_OUT;
  logic [23:0]  DAT1_OUT;
  logic [3:0]   USR_OUT;
  logic         VLD_OUT;
  logic         RDY_IN;

  prt_scaler_slw_mux_pipe dut (
    .CLK_IN   (CLK_IN),
    .RST_IN   (RST_IN),
    .DAT_IN   (DAT_IN),
    .SEL_IN   (SEL_IN),
    .USR_IN   (USR_IN),
    .VLD_IN   (VLD_IN),
    .RDY_OUT  (RDY_OUT),
    .DAT0_OUT (DAT0_OUT),
    .DAT1_OUT (DAT1_OUT),
    .USR_OUT  (USR_OUT),
    .VLD_OUT  (VLD_OUT),
    .RDY_IN   (RDY_IN)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [23:0] d0;
    logic [23:0] d1;
    logic [3:0]  u;
  } beat_t;

  // Hand-computed taps for window bytes k*16+c, indexed by raw SEL_IN (7 clamps to 6).
  logic [23:0] exp0_tab [8] = '{24'h020100, 24'h121110, 24'h222120, 24'h323130,
                                24'h424140, 24'h525150, 24'h626160, 24'h626160};
  logic [23:0] exp1_tab [8] = '{24'h121110, 24'h222120, 24'h323130, 24'h424140,
                                24'h525150, 24'h626160, 24'h626160, 24'h626160};

  beat_t       sb_q[$];
  beat_t       exp_cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  bit          acc_now = 1'b0;
  bit          use_pat = 1'b0;
  int          pat_idx = 0;
  logic [31:0] rdy_pat = 32'hB4E2_59C6;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: occupancy invariants, pop/compare on consumed beats, push on accepts.
  always @(negedge CLK_IN) begin
    acc_now = 1'b0;
    if (RST_IN) begin
      sb_q.delete();
    end else begin
      chk("vld_out_occ", 64'(VLD_OUT), 64'(sb_q.size() > 0));
      chk("rdy_out_occ", 64'(RDY_OUT), 64'(sb_q.size() < 2));
      if (VLD_OUT && RDY_IN) begin
        if (sb_q.size() == 0) begin
          chk("pop_nonempty", 64'(0), 64'(1));
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          n_pop++;
          $display("beat out: usr=%0h dat0=%06h dat1=%06h", USR_OUT, DAT0_OUT, DAT1_OUT);
          chk("dat0", 64'(DAT0_OUT), 64'(e.d0));
          chk("dat1", 64'(DAT1_OUT), 64'(e.d1));
          chk("usr", 64'(USR_OUT), 64'(e.u));
        end
      end
      if (VLD_IN && RDY_OUT) begin
        sb_q.push_back(exp_cur);
        n_acc++;
        acc_now = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge CLK_IN);
    #1;
    if (use_pat) begin
      RDY_IN  = rdy_pat[pat_idx];
      pat_idx = (pat_idx + 1) % 32;
    end
  endtask

  task automatic set_beat(input int sel, input int usr);
    SEL_IN    = 3'(sel);
    USR_IN    = 4'(usr);
    exp_cur.d0 = exp0_tab[sel];
`ifdef PRT_SCALER_SLW_MUX_PAIR_EN
    exp_cur.d1 = exp1_tab[sel];
`else
    exp_cur.d1 = 24'h0;
`endif
    exp_cur.u = 4'(usr);
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send(input int sel, input int usr);
    int guard;
    set_beat(sel, usr);
    VLD_IN = 1'b1;
    guard  = 0;
    do begin
      step();
      guard++;
    end while (!acc_now && guard < 50);
    if (!acc_now) chk("send_accept_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, guard;
    RST_IN = 1'b1;
    VLD_IN = 1'b0;
    RDY_IN = 1'b0;
    SEL_IN = '0;
    USR_IN = '0;
    exp_cur = '{24'h0, 24'h0, 4'h0};
    for (int k = 0; k < 7; k++)
      for (int c = 0; c < 3; c++)
        DAT_IN[(k*3+c)*8 +: 8] = 8'(k*16 + c);

    repeat (3) step();
    RST_IN = 1'b0;
    step();
    chk("rst_vld_out", 64'(VLD_OUT), 64'(0));
    chk("rst_rdy_out", 64'(RDY_OUT), 64'(1));
    chk("rst_dat0", 64'(DAT0_OUT), 64'(0));
    chk("rst_dat1", 64'(DAT1_OUT), 64'(0));
    chk("rst_usr", 64'(USR_OUT), 64'(0));

    // Basic select with one-cycle latency.
    RDY_IN = 1'b1;
    send(3, 1);
    VLD_IN = 1'b0;
    chk("sel3_vld", 64'(VLD_OUT), 64'(1));
    chk("sel3_dat0", 64'(DAT0_OUT), 64'h323130);
    step();

    // Right edge and out-of-range select, back to back.
    send(6, 2);
    send(7, 3);
    VLD_IN = 1'b0;
    chk("sel7_dat0", 64'(DAT0_OUT), 64'h626160);
    step();
    step();

    // 20-beat stream under a fixed irregular ready pattern.
    use_pat = 1'b1;
    for (int i = 0; i < 20; i++) send(i % 8, i);
    VLD_IN  = 1'b0;
    use_pat = 1'b0;
    RDY_IN  = 1'b1;
    guard   = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("stream_drained", 64'(sb_q.size()), 64'(0));

    // Stall for three cycles: exactly two beats absorbed.
    RDY_IN = 1'b0;
    a0 = n_acc;
    set_beat(1, 4); VLD_IN = 1'b1;
    step();
    set_beat(2, 5);
    step();
    chk("stall_rdy_after_2nd", 64'(RDY_OUT), 64'(0));
    set_beat(4, 6);
    step();
    VLD_IN = 1'b0;
    chk("stall_accepts", 64'(n_acc - a0), 64'(2));
    chk("stall_rdy_out", 64'(RDY_OUT), 64'(0));
    p0 = n_pop;
    RDY_IN = 1'b1;
    step();
    step();
    chk("drain_pops", 64'(n_pop - p0), 64'(2));
    chk("drain_vld_out", 64'(VLD_OUT), 64'(0));

    // Reset with the skid full, then a fresh beat comes out first.
    RDY_IN = 1'b0;
    set_beat(4, 10); VLD_IN = 1'b1;
    step();
    set_beat(5, 11);
    step();
    chk("pre_rst_rdy", 64'(RDY_OUT), 64'(0));
    VLD_IN = 1'b0;
    RST_IN = 1'b1;
    step();
    chk("mid_rst_vld_out", 64'(VLD_OUT), 64'(0));
    chk("mid_rst_rdy_out", 64'(RDY_OUT), 64'(1));
    RST_IN = 1'b0;
    RDY_IN = 1'b1;
    p0 = n_pop;
    send(0, 12);
    VLD_IN = 1'b0;
    chk("post_rst_dat0", 64'(DAT0_OUT), 64'h020100);
    chk("post_rst_usr", 64'(USR_OUT), 64'hC);
    step();
    chk("post_rst_pops", 64'(n_pop - p0), 64'(1));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
